ahb_lite_master: RTL and testbench

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

---
 rtl/ahb_lite_pkg.sv | 41 ++++
 rtl/ahb_lite_master_if.sv | 39 +++
 rtl/ahb_lite_master.sv | 121 ++++++++++++
 tb/tb_ahb_lite_master.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-lite encodings, the command record and the legality check used by the master.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [3:0]  prot;
    } cmd_t;

    localparam cmd_t CMD_RST = '{write: 1'b0, addr: 32'd0, wdata: 32'd0,
                                 size: HSIZE_BYTE, prot: HPROT_DEFAULT};

    // Sizes above a word and misaligned halfword/word accesses never reach the bus.
    function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            HSIZE_BYTE: cmd_legal = 1'b1;
            HSIZE_HALF: cmd_legal = (lsb[0] == 1'b0);
            HSIZE_WORD: cmd_legal = (lsb == 2'b00);
            default:    cmd_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_master_if.sv
// Command/response handshake plus AHB-lite bus signals of the single-transfer master.
interface ahb_lite_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [2:0]  cmd_size;
    logic [3:0]  cmd_prot;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size, cmd_prot,
        input  HRDATA, HREADY, HRESP,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size, cmd_prot,
        output HRDATA, HREADY, HRESP,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA
    );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-lite single-transfer master: one address phase overlapped with one data phase, in-order responses.
// Zero-wait latency accept+3 cycles; cmd_ready drops while the address slot is occupied and stalled.
module ahb_lite_master
    import ahb_lite_pkg::*;
(
    input  logic              HMASTCLOCK,
    input  logic              HRESET,
    ahb_lite_master_if.master bus
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_DATA = 3'd2;
    localparam logic [2:0] ST_DATA      = 3'd3;
    localparam logic [2:0] ST_ERR2      = 3'd4;

    logic [2:0]  st_q, st_d;
    logic        keep_q, keep_d;
    cmd_t        a_q, a_d;
    logic        d_write_q, d_write_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic legal, a_vld, d_vld, err2, hresp_err;
    logic a_adv, d_done, err_start, accept;
    logic a_nxt, d_nxt, e_nxt;

    assign legal     = cmd_legal(bus.cmd_size, bus.cmd_addr[1:0]);
    assign hresp_err = (bus.HRESP == HRESP_ERROR);
    assign err2      = (st_q == ST_ERR2);
    assign a_vld     = (st_q == ST_ADDR) || (st_q == ST_ADDR_DATA) || (err2 && keep_q);
    assign d_vld     = (st_q == ST_ADDR_DATA) || (st_q == ST_DATA) || err2;

    // The address phase only moves while no error response is in progress.
    assign a_adv     = a_vld && bus.HREADY && !hresp_err && !err2;
    assign d_done    = d_vld && bus.HREADY;
    assign err_start = d_vld && !err2 && hresp_err && !bus.HREADY;

    assign bus.cmd_ready = legal ? (!a_vld || a_adv) : (st_q == ST_IDLE);
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    assign a_nxt = (a_vld && !a_adv) || (accept && legal);
    assign d_nxt = (d_vld && !d_done) || a_adv;
    assign e_nxt = err_start || (err2 && !d_done);

    always_comb begin
        st_d   = ST_IDLE;
        keep_d = 1'b0;
        if (e_nxt) begin
            st_d   = ST_ERR2;
            keep_d = a_nxt;
        end else begin
            case ({a_nxt, d_nxt})
                2'b10:   st_d = ST_ADDR;
                2'b11:   st_d = ST_ADDR_DATA;
                2'b01:   st_d = ST_DATA;
                default: st_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        a_d = a_q;
        if (accept && legal) begin
            a_d = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata,
                    size: bus.cmd_size, prot: bus.cmd_prot};
        end
        hwdata_d  = a_adv ? a_q.wdata : hwdata_q;
        d_write_d = a_adv ? a_q.write : d_write_q;
    end

    always_comb begin
        rsp_valid_d = d_done || (accept && !legal);
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        if (d_done) begin
            rsp_err_d   = hresp_err;
            rsp_rdata_d = d_write_q ? 32'd0 : bus.HRDATA;
        end else if (accept && !legal) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
        end
    end

    always_ff @(posedge HMASTCLOCK or posedge HRESET) begin
        if (HRESET) begin
            st_q        <= ST_IDLE;
            keep_q      <= 1'b0;
            a_q         <= CMD_RST;
            d_write_q   <= 1'b0;
            hwdata_q    <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            st_q        <= st_d;
            keep_q      <= keep_d;
            a_q         <= a_d;
            d_write_q   <= d_write_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // IDLE is forced from HRESP directly so the first error cycle never presents a live NONSEQ.
    assign bus.HTRANS    = (a_vld && !hresp_err && !err2) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR     = a_q.addr;
    assign bus.HWRITE    = a_q.write;
    assign bus.HSIZE     = a_q.size;
    assign bus.HPROT     = a_q.prot;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HWDATA    = hwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed-vector bench for ahb_lite_master; the bench plays the AHB slave cycle by cycle.
module tb_ahb_lite_master;

    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;

    ahb_lite_master_if bus();

    ahb_lite_master dut (
        .HMASTCLOCK (clk),
        .HRESET     (rst),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] s, input logic [3:0] p);
        bus.cmd_valid = v;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_size  = s;
        bus.cmd_prot  = p;
    endtask

    task automatic slave(input logic rdy, input logic resp, input logic [31:0] rd);
        bus.HREADY = rdy;
        bus.HRESP  = resp;
        bus.HRDATA = rd;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        set_cmd(1'b0, 1'b0, 32'd0, 32'd0, 3'd2, 4'b0011);
        slave(1'b1, 1'b0, 32'd0);
        #2;
        chk("rst_htrans", bus.HTRANS, 2'b00);
        chk("rst_haddr", bus.HADDR, 32'd0);
        chk("rst_hwrite", bus.HWRITE, 1'b0);
        chk("rst_hsize", bus.HSIZE, 3'd0);
        chk("rst_hburst", bus.HBURST, 3'd0);
        chk("rst_hprot", bus.HPROT, 4'b0011);
        chk("rst_hwdata", bus.HWDATA, 32'd0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rel_cmd_ready", bus.cmd_ready, 1'b1);

        // zero-wait read of 0x40
        tick();
        set_cmd(1'b1, 1'b0, 32'h40, 32'd0, 3'd2, 4'b0001);
        #1;
        chk("rd0_ready", bus.cmd_ready, 1'b1);
        chk("rd0_idle_pre", bus.HTRANS, 2'b00);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'd0, 3'd2, 4'b0011);
        #1;
        chk("rd0_nonseq", bus.HTRANS, 2'b10);
        chk("rd0_haddr", bus.HADDR, 32'h40);
        chk("rd0_hwrite", bus.HWRITE, 1'b0);
        chk("rd0_hsize", bus.HSIZE, 3'd2);
        chk("rd0_hprot", bus.HPROT, 4'b0001);
        tick();
        slave(1'b1, 1'b0, 32'h10000000);
        #1;
        chk("rd0_idle_data", bus.HTRANS, 2'b00);
        chk("rd0_no_rsp_yet", bus.rsp_valid, 1'b0);
        tick();
        slave(1'b1, 1'b0, 32'd0);
        #1;
        chk("rd0_rsp_valid", bus.rsp_valid, 1'b1);
        chk("rd0_rsp_rdata", bus.rsp_rdata, 32'h10000000);
        chk("rd0_rsp_err", bus.rsp_err, 1'b0);
        tick();
        chk("rd0_rsp_pulse", bus.rsp_valid, 1'b0);

        // write 0x10 then read 0x14 back to back, two wait states each
        set_cmd(1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 3'd2, 4'b0011);
        tick();
        set_cmd(1'b1, 1'b0, 32'h14, 32'd0, 3'd2, 4'b0011);
        #1;
        chk("wr_nonseq", bus.HTRANS, 2'b10);
        chk("wr_haddr", bus.HADDR, 32'h10);
        chk("wr_hwrite", bus.HWRITE, 1'b1);
        chk("wr_rd_ready", bus.cmd_ready, 1'b1);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'd0, 3'd2, 4'b0011);
        slave(1'b0, 1'b0, 32'd0);
        #1;
        chk("b2b_nonseq", bus.HTRANS, 2'b10);
        chk("b2b_haddr", bus.HADDR, 32'h14);
        chk("b2b_hwrite", bus.HWRITE, 1'b0);
        chk("wr_hwdata_c1", bus.HWDATA, 32'hCAFEF00D);
        tick();
        #1;
        chk("wr_hwdata_c2", bus.HWDATA, 32'hCAFEF00D);
        chk("rd_hold_nonseq", bus.HTRANS, 2'b10);
        tick();
        slave(1'b1, 1'b0, 32'd0);
        #1;
        chk("wr_hwdata_c3", bus.HWDATA, 32'hCAFEF00D);
        chk("wr_no_rsp_yet", bus.rsp_valid, 1'b0);
        tick();
        slave(1'b0, 1'b0, 32'd0);
        #1;
        chk("wr_rsp_valid", bus.rsp_valid, 1'b1);
        chk("wr_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("wr_rsp_err", bus.rsp_err, 1'b0);
        chk("rd1_idle_data", bus.HTRANS, 2'b00);
        tick();
        #1;
        chk("rd1_wait_rsp", bus.rsp_valid, 1'b0);
        tick();
        slave(1'b1, 1'b0, 32'h5A5A1234);
        tick();
        slave(1'b1, 1'b0, 32'd0);
        #1;
        chk("rd1_rsp_valid", bus.rsp_valid, 1'b1);
        chk("rd1_rsp_rdata", bus.rsp_rdata, 32'h5A5A1234);
        chk("rd1_rsp_err", bus.rsp_err, 1'b0);

        // write 0x20 errors while read 0x24 waits in the address phase
        set_cmd(1'b1, 1'b1, 32'h20, 32'h11112222, 3'd2, 4'b0011);
        tick();
        set_cmd(1'b1, 1'b0, 32'h24, 32'd0, 3'd2, 4'b0011);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'd0, 3'd2, 4'b0011);
        slave(1'b0, 1'b1, 32'd0);
        #1;
        chk("err1_htrans_idle", bus.HTRANS, 2'b00);
        chk("err1_cmd_ready", bus.cmd_ready, 1'b0);
        tick();
        slave(1'b1, 1'b1, 32'd0);
        #1;
        chk("err2_htrans_idle", bus.HTRANS, 2'b00);
        chk("err2_haddr_kept", bus.HADDR, 32'h24);
        tick();
        slave(1'b1, 1'b0, 32'd0);
        #1;
        chk("err_rsp_valid", bus.rsp_valid, 1'b1);
        chk("err_rsp_err", bus.rsp_err, 1'b1);
        chk("err_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("reissue_nonseq", bus.HTRANS, 2'b10);
        chk("reissue_haddr", bus.HADDR, 32'h24);
        tick();
        slave(1'b1, 1'b0, 32'hDEADBEEF);
        #1;
        chk("reissue_no_rsp", bus.rsp_valid, 1'b0);
        tick();
        slave(1'b1, 1'b0, 32'd0);
        #1;
        chk("reissue_rsp_valid", bus.rsp_valid, 1'b1);
        chk("reissue_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        chk("reissue_rsp_err", bus.rsp_err, 1'b0);

        // illegal commands with the pipeline empty
        set_cmd(1'b1, 1'b0, 32'h2, 32'd0, 3'd2, 4'b0011);
        #1;
        chk("ill_w_ready", bus.cmd_ready, 1'b1);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'd0, 3'd2, 4'b0011);
        #1;
        chk("ill_w_htrans", bus.HTRANS, 2'b00);
        chk("ill_w_rsp_valid", bus.rsp_valid, 1'b1);
        chk("ill_w_rsp_err", bus.rsp_err, 1'b1);
        chk("ill_w_rsp_rdata", bus.rsp_rdata, 32'd0);
        tick();
        set_cmd(1'b1, 1'b1, 32'h100, 32'h12345678, 3'd3, 4'b0011);
        #1;
        chk("ill_s3_ready", bus.cmd_ready, 1'b1);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'd0, 3'd2, 4'b0011);
        #1;
        chk("ill_s3_htrans", bus.HTRANS, 2'b00);
        chk("ill_s3_rsp_valid", bus.rsp_valid, 1'b1);
        chk("ill_s3_rsp_err", bus.rsp_err, 1'b1);

        // illegal command refused while a transfer is outstanding
        set_cmd(1'b1, 1'b0, 32'h30, 32'd0, 3'd2, 4'b0011);
        tick();
        set_cmd(1'b1, 1'b0, 32'h31, 32'd0, 3'd1, 4'b0011);
        #1;
        chk("ill_busy_ready_a", bus.cmd_ready, 1'b0);
        tick();
        #1;
        chk("ill_busy_ready_d", bus.cmd_ready, 1'b0);
        chk("ill_busy_htrans", bus.HTRANS, 2'b00);
        tick();
        #1;
        chk("ill_busy_rsp_ok", bus.rsp_err, 1'b0);
        chk("ill_idle_ready", bus.cmd_ready, 1'b1);
        set_cmd(1'b0, 1'b0, 32'h0, 32'd0, 3'd2, 4'b0011);

        // reset during a data-phase wait state
        tick();
        set_cmd(1'b1, 1'b0, 32'h44, 32'h77777777, 3'd2, 4'b0011);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'd0, 3'd2, 4'b0011);
        tick();
        slave(1'b0, 1'b0, 32'd0);
        #1;
        chk("pre_rst_hwdata", bus.HWDATA, 32'h77777777);
        rst = 1'b1;
        #1;
        chk("mid_rst_htrans", bus.HTRANS, 2'b00);
        chk("mid_rst_haddr", bus.HADDR, 32'd0);
        chk("mid_rst_hprot", bus.HPROT, 4'b0011);
        chk("mid_rst_hwdata", bus.HWDATA, 32'd0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
        tick();
        rst = 1'b0;
        slave(1'b1, 1'b0, 32'hFFFF0000);
        #1;
        chk("post_rst_ready", bus.cmd_ready, 1'b1);
        chk("post_rst_no_rsp0", bus.rsp_valid, 1'b0);
        tick();
        chk("post_rst_no_rsp1", bus.rsp_valid, 1'b0);
        set_cmd(1'b1, 1'b1, 32'h8, 32'h0BADCAFE, 3'd1, 4'b0011);
        tick();
        set_cmd(1'b0, 1'b0, 32'h0, 32'd0, 3'd2, 4'b0011);
        #1;
        chk("post_wr_nonseq", bus.HTRANS, 2'b10);
        chk("post_wr_haddr", bus.HADDR, 32'h8);
        chk("post_wr_hsize", bus.HSIZE, 3'd1);
        tick();
        chk("post_wr_hwdata", bus.HWDATA, 32'h0BADCAFE);
        tick();
        chk("post_wr_rsp_valid", bus.rsp_valid, 1'b1);
        chk("post_wr_rsp_err", bus.rsp_err, 1'b0);
        chk("post_wr_rsp_rdata", bus.rsp_rdata, 32'd0);
        tick();
        chk("post_wr_rsp_pulse", bus.rsp_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
